bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
- Down-counting BCD timer for the MyClock design, i.e. the countdown counterpart of the up-counting 74LS161-style counter chain.
- Holds a preset MM:SS value and decrements it once per external 1 Hz tick enable.
- Flags expiry with a one-cycle done pulse and a level zero flag.
- Feeds the same 7-segment display path as the clock counters.

Parameters:
- SEC_TENS_MAX, 5, highest legal seconds-tens digit (5 gives a 00–59 seconds field; 9 gives plain 00–99).
- MIN_TENS_MAX, 9, highest legal minutes-tens digit.

Ports:
- CP  in  1  system clock; all state changes on the rising edge.
- CR  in  1  asynchronous, active-high reset.
- tick  in  1  one-CP-cycle count enable (1 Hz strobe).
- load  in  1  synchronous preset load.
- start  in  1  start/resume request (level sampled each CP).
- pause  in  1  pause request.
- D_min  in  8  preset minutes, BCD {tens, ones}.
- D_sec  in  8  preset seconds, BCD {tens, ones}.
- Q_min  out  8  current minutes, BCD.
- Q_sec  out  8  current seconds, BCD.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- done  out  1  one-cycle expiry pulse.
- Bo  out  1  zero/borrow flag, 1 when Q_min:Q_sec == 00:00 (combinational from Q).

Behaviour:
- CR=1 (async): Q_min=Q_sec=8'h00, state=IDLE, done=0; Bo therefore 1. All outputs are registered except Bo.
- Priority each edge: CR > load > pause > start > tick.
- load (any state):
  - Q <= preset after clamping: any ones digit >9 → 9; seconds tens >SEC_TENS_MAX → SEC_TENS_MAX; minutes tens >MIN_TENS_MAX → MIN_TENS_MAX.
  - state <= IDLE; done <= 0; a coincident tick is discarded.
- IDLE:
  - start with Q != 00:00 → RUN.
  - start with Q == 00:00 → remain IDLE.
  - tick ignored.
- RUN:
  - pause → PAUSE; a coincident tick is dropped.
  - start ignored.
  - On tick, decrement Q by one second with BCD borrow chain:
    - seconds ones 0→9 with borrow;
    - seconds tens 0→SEC_TENS_MAX with borrow;
    - minutes ones 0→9 with borrow;
    - minutes tens decrements.
  - Tick taking Q from 00:01 to 00:00: state <= DONE and done=1 on that same edge, i.e. visible the cycle Q first reads 00:00, for exactly one cycle.
- PAUSE:
  - Q frozen; tick ignored.
  - start → RUN; pause ignored.
- DONE:
  - Q held at 00:00; tick, start and pause ignored.
  - Left only by load or CR.
- start and pause asserted in the same cycle: pause wins (RUN→PAUSE); in IDLE/PAUSE no state change.
- A latency of 1 CP from tick to the Q update; no multi-cycle operations.
- CR mid-count: immediate clear regardless of tick or state.
- done never asserts outside a RUN→DONE transition (or an auto-reload event, below).

Optional Feature:
- Macro BCD_DOWN_TIMER_AUTORELOAD_EN.
- When defined:
  - An internal 16-bit preset register captures the clamped D_min/D_sec on every load.
  - On reaching 00:00 the block pulses done but stays in RUN; DONE is unreachable.
  - The next tick at 00:00 reloads Q from the preset register instead of decrementing.
  - A preset of 00:00 in this mode keeps Q at 00:00, pulsing done on each tick.
  - pause/start still work as in RUN/PAUSE.
- When undefined: no preset register exists and behaviour is exactly as above.

Test Plan:
- CR=1 asynchronously mid-RUN at Q=12:34 → Q=00:00, state=00, done=0, Bo=1 before the next CP edge.
- load D=01:00, start, then 1 tick → Q=00:59 (tens borrow 0→5, minutes 1→0), state=01.
- load D=00:02, start, 2 ticks → Q=00:00 after the 2nd tick, done high exactly one cycle, state=11; a further 3 ticks leave Q=00:00 and done=0.
- load D=7A:6F (invalid BCD) → Q=79:59; start and 1 tick → Q=79:58.
- RUN at Q=10:00, pause and tick in the same cycle → state=10, Q=10:00; a tick while paused → no change; start → RUN; tick → Q=09:59.
- With the macro defined: load 00:02, start, 3 ticks → Q 00:01, 00:00 (done pulse, state stays 01), then 00:02.

Source files
------------

// File: rtl/bcd_down_timer_if.sv
// Control, preset and status bundle for bcd_down_timer.
// The master side drives tick/load/start/pause and the preset; the slave side returns the count.
interface bcd_down_timer_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [7:0] D_min;
    logic [7:0] D_sec;
    logic [7:0] Q_min;
    logic [7:0] Q_sec;
    logic [1:0] state;
    logic       done;
    logic       Bo;

    modport master (
        output tick, load, start, pause, D_min, D_sec,
        input  Q_min, Q_sec, state, done, Bo
    );

    modport slave (
        input  tick, load, start, pause, D_min, D_sec,
        output Q_min, Q_sec, state, done, Bo
    );
endinterface

// File: rtl/bcd_down_timer.sv
// MM:SS BCD countdown timer, one decrement per tick strobe, with done pulse and zero flag.
// Define BCD_DOWN_TIMER_AUTORELOAD_EN to reload the last preset on the tick after expiry.
module bcd_down_timer #(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic             CP,
    input  logic             CR,
    bcd_down_timer_if.slave  bus
);

    localparam logic [3:0] SecTensLim = SEC_TENS_MAX[3:0];
    localparam logic [3:0] MinTensLim = MIN_TENS_MAX[3:0];
    localparam logic [3:0] OnesLim    = 4'd9;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        done_q, done_d;
    logic [15:0] preset_clamped;
    logic [15:0] count_dec;
    logic        is_zero;

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
    logic [15:0] preset_q, preset_d;
`endif

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Borrow ripples from seconds-ones up; only ever applied to a non-zero count.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = OnesLim;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = SecTensLim;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = OnesLim;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign preset_clamped = {clamp_digit(bus.D_min[7:4], MinTensLim),
                             clamp_digit(bus.D_min[3:0], OnesLim),
                             clamp_digit(bus.D_sec[7:4], SecTensLim),
                             clamp_digit(bus.D_sec[3:0], OnesLim)};
    assign count_dec = bcd_dec(count_q);
    assign is_zero   = (count_q == 16'h0000);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        preset_d = preset_q;
`endif
        if (bus.load) begin
            count_d = preset_clamped;
            state_d = StIdle;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
            preset_d = preset_clamped;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !bus.pause && !is_zero) state_d = StRun;
                end
                StRun: begin
                    if (bus.pause) begin
                        state_d = StPause;
                    end else if (bus.tick) begin
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                        count_d = is_zero ? preset_q : count_dec;
                        done_d  = (count_d == 16'h0000);
`else
                        count_d = count_dec;
                        if (count_d == 16'h0000) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
`endif
                    end
                end
                StPause: begin
                    if (bus.start && !bus.pause) state_d = StRun;
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= StIdle;
            count_q <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
    always_ff @(posedge CP or posedge CR) begin
        if (CR) preset_q <= 16'h0000;
        else    preset_q <= preset_d;
    end
`endif

    assign bus.Q_min = count_q[15:8];
    assign bus.Q_sec = count_q[7:0];
    assign bus.state = state_q;
    assign bus.done  = done_q;
    assign bus.Bo    = is_zero;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: directed literal checks plus random stimulus against a
// remaining-seconds model; honours BCD_DOWN_TIMER_AUTORELOAD_EN when defined.
module tb_bcd_down_timer;

    localparam int SecMod = 60;

    logic CP = 1'b0;
    logic CR = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    bcd_down_timer_if bus ();

    bcd_down_timer #(
        .SEC_TENS_MAX(5),
        .MIN_TENS_MAX(9)
    ) dut (
        .CP (CP),
        .CR (CR),
        .bus(bus)
    );

    always #5 CP = ~CP;

    // Model: time left as a plain number of seconds, status as small ints.
    int m_total  = 0;
    int m_state  = 0;
    bit m_done   = 1'b0;
    int m_preset = 0;

    function automatic int dmin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int preset_secs(input logic [7:0] mi, input logic [7:0] se);
        int mt, mo, st, so;
        mt = dmin(int'(mi[7:4]), 9);
        mo = dmin(int'(mi[3:0]), 9);
        st = dmin(int'(se[7:4]), 5);
        so = dmin(int'(se[3:0]), 9);
        return (mt * 10 + mo) * SecMod + st * 10 + so;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    always @(posedge CP or posedge CR) begin
        if (CR) begin
            m_total = 0;
            m_state = 0;
            m_done  = 1'b0;
            m_preset = 0;
        end else begin
            m_done = 1'b0;
            if (bus.load) begin
                m_total  = preset_secs(bus.D_min, bus.D_sec);
                m_preset = m_total;
                m_state  = 0;
            end else begin
                case (m_state)
                    0: if (bus.start && !bus.pause && m_total != 0) m_state = 1;
                    1: begin
                        if (bus.pause) begin
                            m_state = 2;
                        end else if (bus.tick) begin
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                            m_total = (m_total == 0) ? m_preset : m_total - 1;
                            m_done  = (m_total == 0);
`else
                            m_total = m_total - 1;
                            if (m_total == 0) begin
                                m_done  = 1'b1;
                                m_state = 3;
                            end
`endif
                        end
                    end
                    2: if (bus.start && !bus.pause) m_state = 1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge CP) begin
        if (cmp_en) begin
            logic [7:0] em, es;
            em = to_bcd(m_total / SecMod);
            es = to_bcd(m_total % SecMod);
            checks++;
            if (bus.Q_min !== em || bus.Q_sec !== es || bus.state !== 2'(m_state) ||
                bus.done !== m_done || bus.Bo !== (m_total == 0)) begin
                errors++;
                $display("FAIL model t=%0t got Q=%h:%h st=%0d done=%b Bo=%b want Q=%h:%h st=%0d done=%b Bo=%b",
                         $time, bus.Q_min, bus.Q_sec, bus.state, bus.done, bus.Bo,
                         em, es, m_state, m_done, (m_total == 0));
            end
        end
    end

    // Drive one cycle's inputs just after an edge, then return inputs to idle.
    task automatic step(input bit l, input bit s, input bit p, input bit t,
                        input logic [7:0] mi = 8'h00, input logic [7:0] se = 8'h00);
        bus.load  = l;
        bus.start = s;
        bus.pause = p;
        bus.tick  = t;
        bus.D_min = mi;
        bus.D_sec = se;
        @(posedge CP);
        #2;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        bus.tick  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] em, input logic [7:0] es,
                       input logic [1:0] est, input bit ed);
        checks++;
        if (bus.Q_min !== em || bus.Q_sec !== es || bus.state !== est || bus.done !== ed ||
            bus.Bo !== (em == 8'h00 && es == 8'h00)) begin
            errors++;
            $display("FAIL %s got Q=%h:%h st=%0d done=%b Bo=%b want Q=%h:%h st=%0d done=%b",
                     name, bus.Q_min, bus.Q_sec, bus.state, bus.done, bus.Bo, em, es, est, ed);
        end
    endtask

    initial begin
        bit l, s, p, t;
        logic [7:0] mi, se;
        bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
        bus.D_min = 8'h00; bus.D_sec = 8'h00;
        #12;
        chk("reset", 8'h00, 8'h00, 2'd0, 1'b0);
        @(posedge CP); #2;
        CR = 1'b0;
        cmp_en = 1'b1;

        // Asynchronous clear mid-run.
        step(1, 0, 0, 0, 8'h12, 8'h34);
        step(0, 1, 0, 0);
        chk("run_12_34", 8'h12, 8'h34, 2'd1, 1'b0);
        #1 CR = 1'b1;
        #1 chk("async_clear", 8'h00, 8'h00, 2'd0, 1'b0);
        CR = 1'b0;

        step(1, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 0);
        chk("start_at_zero", 8'h00, 8'h00, 2'd0, 1'b0);

        step(1, 0, 0, 0, 8'h01, 8'h00);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("borrow_01_00", 8'h00, 8'h59, 2'd1, 1'b0);

        step(1, 0, 0, 0, 8'h00, 8'h02);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("tick_to_01", 8'h00, 8'h01, 2'd1, 1'b0);
        step(0, 0, 0, 1);
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        chk("expire_ar", 8'h00, 8'h00, 2'd1, 1'b1);
        step(0, 0, 0, 1);
        chk("reload", 8'h00, 8'h02, 2'd1, 1'b0);
`else
        chk("expire", 8'h00, 8'h00, 2'd3, 1'b1);
        step(0, 0, 0, 0);
        chk("done_one_cycle", 8'h00, 8'h00, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        chk("done_hold", 8'h00, 8'h00, 2'd3, 1'b0);
`endif

        step(1, 0, 0, 1, 8'h7A, 8'h6F);
        chk("clamp", 8'h79, 8'h59, 2'd0, 1'b0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("clamp_tick", 8'h79, 8'h58, 2'd1, 1'b0);

        step(1, 0, 0, 0, 8'h10, 8'h00);
        step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        chk("pause_drop_tick", 8'h10, 8'h00, 2'd2, 1'b0);
        step(0, 0, 0, 1);
        chk("paused_tick", 8'h10, 8'h00, 2'd2, 1'b0);
        step(0, 1, 0, 0);
        chk("resume", 8'h10, 8'h00, 2'd1, 1'b0);
        step(0, 0, 0, 1);
        chk("borrow_10_00", 8'h09, 8'h59, 2'd1, 1'b0);

        // Random traffic, biased toward short presets so expiry happens often.
        for (int i = 0; i < 4000; i++) begin
            l  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            p  = ($urandom_range(0, 99) < 6);
            t  = ($urandom_range(0, 99) < 40);
            mi = ($urandom_range(0, 3) != 0) ? 8'h00 : 8'($urandom);
            se = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 18)) : 8'($urandom);
            step(l, s, p, t, mi, se);
        end

        @(negedge CP);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
